// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines of 16-byte blocks,
// zero-stall hits, whole-block refill from instruction memory on a miss.
module instruction_cache #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned INDEX_WIDTH = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDR_WIDTH-1:0]    address,
    output logic [31:0]              readinst,
    output logic                     busywait,
    output logic                     mem_read,
    output logic [ADDR_WIDTH-5:0]    mem_address,
    input  logic [127:0]             mem_readinst,
    input  logic                     mem_busywait
);

    localparam int unsigned OFFSET_WIDTH   = 4;
    localparam int unsigned TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int unsigned BLK_ADDR_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int unsigned LINES          = 1 << INDEX_WIDTH;
    localparam int unsigned BLOCK_WIDTH    = 128;
    localparam int unsigned WORD_WIDTH     = 32;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_READ = 2'd1;
    localparam logic [1:0] ST_UPDATE   = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [LINES-1:0]            valid_q, valid_d;
    logic [TAG_WIDTH-1:0]        tag_q   [LINES];
    logic [TAG_WIDTH-1:0]        tag_d   [LINES];
    logic [BLOCK_WIDTH-1:0]      data_q  [LINES];
    logic [BLOCK_WIDTH-1:0]      data_d  [LINES];
    logic [BLK_ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;

    logic [TAG_WIDTH-1:0]        addr_tag;
    logic [INDEX_WIDTH-1:0]      addr_index;
    logic [1:0]                  addr_word;
    logic [TAG_WIDTH-1:0]        fill_tag;
    logic [INDEX_WIDTH-1:0]      fill_index;
    logic [BLOCK_WIDTH-1:0]      line_data;
    logic                        hit;
    logic                        unused_addr_bits;

    // Address decode; the byte offset within a word is not needed for word fetches
    assign addr_tag         = address[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign addr_index       = address[OFFSET_WIDTH +: INDEX_WIDTH];
    assign addr_word        = address[3:2];
    assign unused_addr_bits = ^address[1:0];

    // The block being filled is identified by the latched {tag,index}, not the live PC
    assign fill_tag    = mem_address_q[BLK_ADDR_WIDTH-1 -: TAG_WIDTH];
    assign fill_index  = mem_address_q[INDEX_WIDTH-1:0];
    assign mem_address = mem_address_q;

    assign line_data = data_q[addr_index];
    assign hit       = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);

    // Word select from the indexed line
    always_comb begin
        readinst = line_data[WORD_WIDTH-1:0];
        case (addr_word)
            2'd0:    readinst = line_data[0*WORD_WIDTH +: WORD_WIDTH];
            2'd1:    readinst = line_data[1*WORD_WIDTH +: WORD_WIDTH];
            2'd2:    readinst = line_data[2*WORD_WIDTH +: WORD_WIDTH];
            default: readinst = line_data[3*WORD_WIDTH +: WORD_WIDTH];
        endcase
    end

    // Miss handling FSM: next state, line install and CPU/memory handshakes
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        data_d        = data_q;
        mem_address_d = mem_address_q;
        busywait      = 1'b1;
        mem_read      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busywait = !hit;
                if (!hit) begin
                    state_d       = ST_MEM_READ;
                    mem_address_d = {addr_tag, addr_index};
                end
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                data_d[fill_index]  = mem_readinst;
                tag_d[fill_index]   = fill_tag;
                valid_d[fill_index] = 1'b1;
                state_d             = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and storage registers; reset clears every line and abandons any fill
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            valid_q       <= '0;
            tag_q         <= '{default: '0};
            data_q        <= '{default: '0};
            mem_address_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            data_q        <= data_d;
            mem_address_q <= mem_address_d;
        end
    end

endmodule
